// File: rtl/systolic_skew_feeder_if.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder_if
// Bundles the tile-load port, the run control and the skewed array-facing
// streams of systolic_skew_feeder.
//   master : the side that loads tiles and issues start/abort
//   slave  : the feeder itself
// Signals:
//   ld_en/ld_sel/ld_addr/ld_data -> tile write port, ld_err <- rejected write
//   start/abort                  -> run control
//   busy/done                    <- run status
//   a0/a4/a8/a12                 <- west streams (rows 0..3)
//   w0..w3                       <- north streams (columns 0..3)
//   WEn/pauseProcess             <- array control
// -----------------------------------------------------------------------------
interface systolic_skew_feeder_if #(
    parameter int DW = 8
) ();
    logic          ld_en;
    logic          ld_sel;
    logic [3:0]    ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_err;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [DW-1:0] a0, a4, a8, a12;
    logic [DW-1:0] w0, w1, w2, w3;
    logic          WEn;
    logic          pauseProcess;

    modport master (
        output ld_en, ld_sel, ld_addr, ld_data, start, abort,
        input  ld_err, busy, done, a0, a4, a8, a12, w0, w1, w2, w3,
               WEn, pauseProcess
    );

    modport slave (
        input  ld_en, ld_sel, ld_addr, ld_data, start, abort,
        output ld_err, busy, done, a0, a4, a8, a12, w0, w1, w2, w3,
               WEn, pauseProcess
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder
// Holds one 4x4 activation tile A and one 4x4 weight tile W and, on start,
// plays them into a 4x4 MAC systolic array as diagonally skewed streams:
// row i of A leaves on the west port i steps late, column j of W leaves on
// the north port j steps late. Seven stream steps are followed by DRAIN_CYC
// zero cycles, then done pulses for one cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : systolic_skew_feeder_if.slave (load port, control, streams)
// -----------------------------------------------------------------------------
module systolic_skew_feeder #(
    parameter int DW        = 8,
    parameter int DRAIN_CYC = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_skew_feeder_if.slave bus
);
    localparam int STREAM_LEN = 7;
    localparam int CNT_MAX    = (DRAIN_CYC > STREAM_LEN) ? DRAIN_CYC : STREAM_LEN;
    localparam int CW         = $clog2(CNT_MAX);

    localparam logic [CW-1:0] STREAM_LAST = CW'(STREAM_LEN - 1);
    localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_CYC - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    logic [1:0]                 state;
    logic [CW-1:0]              cnt;
    logic [3:0][3:0][DW-1:0]    a_buf;      // [row][col]
    logic [3:0][3:0][DW-1:0]    w_buf;      // [row][col]
    logic [3:0][DW-1:0]         a_q, w_q;
    logic [3:0][DW-1:0]         a_nxt, w_nxt;
    logic [CW-1:0]              step_nxt;
    logic                       load_step;
    logic                       wr_ok;
    logic                       en_q, done_q, err_q;

    // A write is taken only while idle and not in the very cycle a run is
    // launched, so a run always sees the tile contents from before start.
    assign wr_ok = bus.ld_en && (state == IDLE) && !bus.start;

    // The output registers take a new skew step at the start edge (step 0)
    // and on every STREAM edge except the last, which hands over to DRAIN.
    assign load_step = ((state == IDLE) && bus.start) ||
                       ((state == STREAM) && !bus.abort && (cnt != STREAM_LAST));
    assign step_nxt  = (state == IDLE) ? '0 : cnt + CW'(1);

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        a_nxt = '0;
        w_nxt = '0;
        // Element (i,k) of A is on the west port of row i at step i+k;
        // element (k,i) of W is on the north port of column i at step k+i.
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (int'(step_nxt) == i + k) begin
                    a_nxt[2'(i)] = a_buf[2'(i)][2'(k)];
                    w_nxt[2'(i)] = w_buf[2'(k)][2'(i)];
                end
            end
        end
    end

    // NOTE: the tile buffers are plain flops and are cleared by reset so a run
    // after reset streams zeros; a RAM macro could not be reset this way.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_buf <= '0;
            w_buf <= '0;
        end else if (wr_ok) begin
            if (bus.ld_sel) begin
                w_buf[bus.ld_addr[3:2]][bus.ld_addr[1:0]] <= bus.ld_data;
            end else begin
                a_buf[bus.ld_addr[3:2]][bus.ld_addr[1:0]] <= bus.ld_data;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            en_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            a_q    <= '0;
            w_q    <= '0;
        end else begin
            err_q  <= bus.ld_en && !wr_ok;
            done_q <= 1'b0;
            a_q    <= load_step ? a_nxt : '0;
            w_q    <= load_step ? w_nxt : '0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= STREAM;
                        cnt   <= '0;
                        en_q  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (bus.abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                        en_q  <= 1'b0;
                    end else if (cnt == STREAM_LAST) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (bus.abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                        en_q  <= 1'b0;
                    end else if (cnt == DRAIN_LAST) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        en_q   <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    en_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a0           = a_q[0];
    assign bus.a4           = a_q[1];
    assign bus.a8           = a_q[2];
    assign bus.a12          = a_q[3];
    assign bus.w0           = w_q[0];
    assign bus.w1           = w_q[1];
    assign bus.w2           = w_q[2];
    assign bus.w3           = w_q[3];
    assign bus.WEn          = en_q;
    assign bus.pauseProcess = en_q;
    assign bus.busy         = en_q;
    assign bus.done         = done_q;
    assign bus.ld_err       = err_q;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_skew_feeder
// Directed bench for systolic_skew_feeder. A 19-entry table holds the start
// input and the expected outputs for one full run (7 stream steps, 11 drain
// cycles, done cycle) with A[i][j]=4i+j+1 and W[i][j]=16+4i+j. Hand-written
// sequences cover loads while busy, abort, back-to-back runs and reset
// during drain.
// -----------------------------------------------------------------------------
module tb_systolic_skew_feeder;
    localparam int DW  = 8;
    localparam int NV  = 19;

    typedef struct packed {
        logic [DW-1:0] a0, a4, a8, a12, w0, w1, w2, w3;
        logic          wen, pause, busy, done;
    } outs_t;

    typedef struct {
        logic  start;
        outs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vec [NV];

    int a0_s  [7] = '{1, 2, 3, 4, 0, 0, 0};
    int a4_s  [7] = '{0, 5, 6, 7, 8, 0, 0};
    int a8_s  [7] = '{0, 0, 9, 10, 11, 12, 0};
    int a12_s [7] = '{0, 0, 0, 13, 14, 15, 16};
    int w0_s  [7] = '{16, 20, 24, 28, 0, 0, 0};
    int w1_s  [7] = '{0, 17, 21, 25, 29, 0, 0};
    int w2_s  [7] = '{0, 0, 18, 22, 26, 30, 0};
    int w3_s  [7] = '{0, 0, 0, 19, 23, 27, 31};

    always #5 clk = ~clk;

    systolic_skew_feeder_if #(.DW(DW)) bus ();

    systolic_skew_feeder #(.DW(DW), .DRAIN_CYC(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic outs_t mk(int a0, int a4, int a8, int a12,
                                 int w0, int w1, int w2, int w3,
                                 logic en, logic dn);
        outs_t o;
        o.a0 = DW'(a0);  o.a4 = DW'(a4);  o.a8 = DW'(a8);  o.a12 = DW'(a12);
        o.w0 = DW'(w0);  o.w1 = DW'(w1);  o.w2 = DW'(w2);  o.w3  = DW'(w3);
        o.wen = en; o.pause = en; o.busy = en; o.done = dn;
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.a0 = bus.a0;  o.a4 = bus.a4;  o.a8 = bus.a8;  o.a12 = bus.a12;
        o.w0 = bus.w0;  o.w1 = bus.w1;  o.w2 = bus.w2;  o.w3  = bus.w3;
        o.wen = bus.WEn; o.pause = bus.pauseProcess; o.busy = bus.busy;
        o.done = bus.done;
        return o;
    endfunction

    task automatic check(input string name, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic sel, input int addr, input int data);
        bus.ld_en   = 1'b1;
        bus.ld_sel  = sel;
        bus.ld_addr = 4'(addr);
        bus.ld_data = DW'(data);
        step();
        bus.ld_en   = 1'b0;
    endtask

    // Applies table entries first..NV-1; hold_start keeps start high on the
    // last entry (ignored in DRAIN) so it stays asserted across done.
    task automatic run_vectors(input int first, input bit hold_start,
                               input bit zero_data, input string tag);
        outs_t e;
        for (int i = first; i < NV; i++) begin
            bus.start = vec[i].start | (hold_start && i == NV - 1);
            step();
            e = vec[i].exp;
            if (zero_data) begin
                e.a0 = '0; e.a4 = '0; e.a8 = '0; e.a12 = '0;
                e.w0 = '0; e.w1 = '0; e.w2 = '0; e.w3  = '0;
            end
            check($sformatf("%s[%0d]", tag, i), sample(), e);
        end
        bus.start = hold_start;
    endtask

    task automatic wait_done(input int budget, input string tag);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            step();
            seen = bus.done;
        end
        check_bit(tag, seen, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic  flag;
        outs_t zeros;
        zeros = mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);

        for (int s = 0; s < NV; s++) begin
            vec[s].start = (s == 0 || s == 3 || s == 12);
            if (s < 7)
                vec[s].exp = mk(a0_s[s], a4_s[s], a8_s[s], a12_s[s],
                                w0_s[s], w1_s[s], w2_s[s], w3_s[s], 1'b1, 1'b0);
            else if (s < NV - 1)
                vec[s].exp = mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
            else
                vec[s].exp = mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        end

        bus.ld_en = 1'b0; bus.ld_sel = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        bus.start = 1'b0; bus.abort = 1'b0;

        // Reset, then a quiet idle period.
        #12;
        check("reset", sample(), zeros);
        check_bit("reset_ld_err", bus.ld_err, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        flag = 1'b0;
        for (int n = 0; n < 50; n++) begin
            step();
            flag = flag | bus.done | bus.busy;
        end
        check_bit("idle_quiet", flag, 1'b0);

        // Load both tiles.
        for (int i = 0; i < 16; i++) begin
            load(1'b0, i, i + 1);
            load(1'b1, i, 16 + i);
        end
        check_bit("load_no_err", bus.ld_err, 1'b0);

        // Full run, then a run started in the done cycle with start held.
        run_vectors(0, 1'b0, 1'b0, "run1");
        run_vectors(0, 1'b1, 1'b0, "b2b_a");
        run_vectors(0, 1'b0, 1'b0, "b2b_b");
        step();

        // Write attempt during STREAM at s=2 is rejected.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        check("ls_s2", sample(), vec[2].exp);
        bus.ld_en = 1'b1; bus.ld_sel = 1'b0; bus.ld_addr = 4'd0; bus.ld_data = 8'hFF;
        step();
        bus.ld_en = 1'b0;
        check_bit("ls_err_pulse", bus.ld_err, 1'b1);
        step();
        check_bit("ls_err_clear", bus.ld_err, 1'b0);
        wait_done(40, "ls_done");
        run_vectors(0, 1'b0, 1'b0, "after_ls");

        // Write in the same cycle start is accepted: ignored, ld_err pulses.
        bus.start = 1'b1;
        bus.ld_en = 1'b1; bus.ld_sel = 1'b0; bus.ld_addr = 4'd0; bus.ld_data = 8'hEE;
        step();
        bus.start = 1'b0;
        bus.ld_en = 1'b0;
        check_bit("ldstart_err", bus.ld_err, 1'b1);
        check("ldstart[0]", sample(), vec[0].exp);
        run_vectors(1, 1'b0, 1'b0, "ldstart");
        step();

        // Abort at s=4: outputs drop next cycle, no done, replay is identical.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int n = 0; n < 4; n++) step();
        check("abort_s4", sample(), vec[4].exp);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_next", sample(), zeros);
        flag = 1'b0;
        for (int n = 0; n < 25; n++) begin
            step();
            flag = flag | bus.done | bus.busy;
        end
        check_bit("abort_no_done", flag, 1'b0);
        run_vectors(0, 1'b0, 1'b0, "replay");

        // abort in IDLE has no effect: start with abort still launches a run.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("idle_abort[0]", sample(), vec[0].exp);
        run_vectors(1, 1'b0, 1'b0, "idle_abort");

        // Reset during DRAIN: outputs clear before the next edge, buffers lost.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int n = 0; n < 10; n++) step();
        check("drain_pre_rst", sample(), vec[10].exp);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst", sample(), zeros);
        @(negedge clk);
        rst = 1'b1;
        step();
        run_vectors(0, 1'b0, 1'b1, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Feeds the 4x4 MAC systolic array from the producer side.
- Buffers one 4x4 activation tile A and one 4x4 weight tile W, loaded through a simple write port.
- On start, drives the diagonally skewed streams the array consumes: west inputs a0/a4/a8/a12 and north inputs w0..w3.
- Also generates the array control signals WEn and pauseProcess, then signals completion once the drain period ends.

Parameters:
- DW, 8, element width of A, W and all stream outputs.
- DRAIN_CYC, 11, cycles of zero padding after the last skewed element (7 stream + 11 drain = 18, matching the array's 18-count window).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- ld_en  input  1  write strobe for the tile buffers.
- ld_sel  input  1  0 = write A buffer, 1 = write W buffer.
- ld_addr  input  4  element index = row*4 + col.
- ld_data  input  DW  element value.
- ld_err  output  1  one-cycle pulse: write was rejected.
- start  input  1  begin streaming; sampled only in IDLE.
- abort  input  1  synchronous abort of streaming/draining.
- busy  output  1  high in STREAM and DRAIN.
- done  output  1  one-cycle pulse at the end of DRAIN.
- a0, a4, a8, a12  output  DW each  west streams, rows 0..3.
- w0, w1, w2, w3  output  DW each  north streams, columns 0..3.
- WEn  output  1  array write enable.
- pauseProcess  output  1  array run enable (array counter runs while high).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; both buffers cleared to 0; all outputs 0; counters 0.
- All outputs are registered.
- States:
  - IDLE:
    - ld_en=1 writes buffer[ld_sel][ld_addr] <= ld_data at the edge.
    - start=1 moves to STREAM and clears the step counter s.
  - STREAM: lasts 7 cycles, s = 0..6.
  - DRAIN: lasts DRAIN_CYC cycles; all stream outputs 0.
  - Exit from DRAIN: after the last DRAIN cycle return to IDLE with done=1 for exactly one cycle.
- Skew rule: the output values visible in the cycle after the edge that registers step s are:
  - a(4i) = A[i][s-i] if 0 <= s-i <= 3, else 0.
  - w(j) = W[s-j][j] if 0 <= s-j <= 3, else 0.
- Latency: the first non-zero-capable output (a0 = A[0][0], w0 = W[0][0]) appears on the first cycle after the edge that accepts start.
- Control outputs:
  - WEn=1 and pauseProcess=1 for every STREAM and DRAIN cycle.
  - Both drop to 0 in the same cycle done pulses.
  - busy tracks WEn.
- Load rules:
  - ld_en in STREAM or DRAIN: write ignored, ld_err=1 next cycle.
  - ld_en in the same cycle start is accepted: write ignored, ld_err pulses, stream uses the prior contents.
  - ld_addr covers all 16 entries; there is no out-of-range case.
- start outside IDLE is ignored; there is no queueing.
- Back-to-back operation: start asserted in the cycle done is high (state IDLE) is accepted, giving zero idle gap.
- abort in STREAM or DRAIN:
  - Next cycle: IDLE, all stream outputs 0, WEn=0, pauseProcess=0, done not pulsed.
  - Buffers are retained.
  - abort in IDLE has no effect.
- Reset mid-operation: immediate return to reset state; buffers are lost.
- Widths: pure data movement with no arithmetic on elements; the counter is wide enough for max(7, DRAIN_CYC).

Test Plan:
- Reset then idle: rst=0 then 1 -> all outputs 0, busy=0, done never pulses over 50 cycles.
- Load A[i][j]=4i+j+1 and W[i][j]=16+4i+j, then pulse start -> a0 sequence 1,2,3,4,0,0,0; a12 sequence 0,0,0,13,14,15,16; w3 sequence 0,0,0,19,23,27,31; then 11 zero cycles; done pulses on cycle 18 after start; WEn high for 18 cycles.
- Load during STREAM (ld_en at s=2, addr 0, data 0xFF) -> ld_err pulse; rerunning start gives a0 first value 1, not 0xFF.
- abort at s=4 -> next cycle busy=0, WEn=0, all streams 0, no done; a new start replays identical sequences.
- start held high across done -> second run begins immediately; a0=1 appears the cycle after done.
- rst=0 asserted during DRAIN -> outputs 0 asynchronously; after release, a start streams all zeros (buffers cleared).
